pa_capture: RTL

Parametrised parallel-input capture block for the UDB-side input path. Samples either an external parallel bus or an internal self-test pattern at a programmable rate and buffers the samples in a small FIFO. The CPU-facing side drains the FIFO. A level interrupt fires when the fill level reaches a threshold. It generalises the fixed 8-bit, single-register, fixed-rate pattern loader to any power-of-two width, a buffered depth, and selectable source and rate.

---
 rtl/pa_capture.sv | 107 ++++++++++
 1 files changed

// File: rtl/pa_capture.sv
// pa_capture: rate-programmable capture of an external bus or an internal test pattern into a first-word fall-through FIFO.
// The FIFO raises a level interrupt and a sticky overflow flag.
module pa_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic             mode_i,
    input  logic [7:0]       div_i,
    input  logic [AW:0]      thresh_i,
    input  logic [WIDTH-1:0] pa_in_i,
    input  logic             rd_en_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      level_o,
    output logic             overflow_o,
    output logic             isr_o
);
    localparam int L = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, WAIT, CAPT} state_e;

    state_e           state_q;
    logic [7:0]       cnt_q;
    logic             mode_q;
    logic [2:0]       idx_q, idx_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      lvl_q, lvl_d, th;
    logic             ovf_q, isr_q;
    logic             capt, push, pop, full, empty;
    logic [WIDTH-1:0] pat, sample;

    always_comb begin
        capt   = enable_i && state_q == CAPT;
        empty  = lvl_q == '0;
        full   = lvl_q == (AW+1)'(DEPTH);
        pop    = rd_en_i && (!empty || capt);
        push   = capt && (!full || pop);
        lvl_d  = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
        th     = thresh_i == '0 ? (AW+1)'(1) : thresh_i;
        idx_d  = mode_i != mode_q ? 3'd0 : idx_q;
        pat    = '1;
        for (int i = 0; i < WIDTH; i++)
            pat[i] = idx_d == 3'd0 ? 1'b1 : 1'(i >> (L - int'(idx_d)));
        sample = mode_i ? pat : pa_in_i;
    end

    // CAPT reloads div-1 so the period is div+1; div=0 still spends one cycle in WAIT.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i || !enable_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= WAIT;
                    cnt_q   <= div_i;
                end
                WAIT: begin
                    state_q <= cnt_q == 8'd0 ? CAPT : WAIT;
                    cnt_q   <= cnt_q == 8'd0 ? 8'd0 : cnt_q - 8'd1;
                end
                default: begin
                    state_q <= WAIT;
                    cnt_q   <= div_i == 8'd0 ? 8'd0 : div_i - 8'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            mode_q <= 1'b0;
            idx_q  <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            lvl_q  <= '0;
            ovf_q  <= 1'b0;
            isr_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mode_q <= mode_i;
            idx_q  <= capt && mode_i ? (idx_d == 3'(L) ? 3'd0 : idx_d + 3'd1) : idx_d;
            if (push) begin
                mem_q[wp_q] <= sample;
                wp_q        <= wp_q + AW'(1);
            end
            if (pop) rp_q <= rp_q + AW'(1);
            lvl_q <= lvl_d;
            ovf_q <= (capt && !push) || (ovf_q && !ovf_clr_i);
            isr_q <= lvl_d >= th;
        end
    end

    assign rd_data_o  = mem_q[rp_q];
    assign empty_o    = empty;
    assign full_o     = full;
    assign level_o    = lvl_q;
    assign overflow_o = ovf_q;
    assign isr_o      = isr_q;
endmodule
